mbtrain_center_sweep_tx: RTL and testbench
==========================================

// Module: mbtrain_center_sweep_tx
// PURPOSE
//  Parametrised MBTRAIN TX center-calibration sequencer: does the sideband start/end req-resp handshake and sweeps
//  the PI phase over PI_STEPS codes, one point test per step. Tracks the longest contiguous all-lanes-pass window
//  and programs its center. Sits between the LTSM MBTRAIN substep controller, the sideband mux and the point-test block.
// PARAMETERS
//  NUM_LANES   16  data lanes whose point-test result is reported per step
//  MSG_W       4   sideband decoded-message width
//  PI_W        4   PI control-word width; PI_STEPS = 2**PI_W codes swept, 0..PI_STEPS-1
//  TIMEOUT_CYC 8000 cycles allowed for each sideband response wait (only with MBTRAIN_SB_TIMEOUT_EN)
// PORTS
//  clk                     in  1         clock
//  rst                     in  1         synchronous reset, active high
//  i_en                    in  1         substep enable; low -> IDLE next edge
//  i_decoded_sideband_message in MSG_W   decoded partner message
//  i_sideband_valid        in  1         message qualifier
//  i_busy_negedge_detected in  1         sideband mux released
//  i_valid_rx              in  1         RX side currently owns the sideband
//  i_mainband_or_valtrain_test in 1      0 mainband, 1 valtrain; passed through to point test
//  i_pt_done               in  1         1-cycle pulse: point test finished
//  i_tx_lanes_result       in  NUM_LANES per-lane pass (1) flags, valid with i_pt_done
//  o_sideband_message      out MSG_W     message to send
//  o_valid_tx              out 1         send request to sideband mux
//  o_pt_en                 out 1         point-test enable (level, one run per step)
//  o_mainband_or_valtrain_test out 1     registered copy of the input at sweep start
//  o_pi_step               out PI_W      PI control word
//  o_test_ack              out 1         substep complete (held until i_en low)
//  o_cal_fail              out 1         no passing step, or timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, window regs 0. All outputs are registered.
//  Messages: START_REQ=1, START_RESP=2, END_REQ=3, END_RESP=4, NONE=0.
//  FSM: IDLE -(i_en)-> START_REQ (drive msg 1) -(msg 2 & valid)-> SETTLE (o_pi_step<=cur, 1 cycle)
//   -> RUN (o_pt_en=1) -(i_pt_done)-> EVAL (o_pt_en=0; update window; cur++) -> SETTLE while cur<PI_STEPS-1 at EVAL,
//   else -> APPLY (o_pi_step<=center, or 0 with o_cal_fail=1 if best_len==0) -> END_REQ (msg 3)
//   -(msg 4 & valid)-> DONE (msg 0, o_test_ack=1) -(~i_en)-> IDLE.
//  i_en low in any state -> IDLE on next edge; outputs cleared as in reset. rst beats i_en.
//  Window: step passes iff &i_tx_lanes_result. run_len/run_start count the current pass run; on fail run_len=0.
//   best updated when run_len_new > best_len (strict: earliest window wins on tie). Run ending at last step is still
//   compared. center = best_start + (best_len-1)/2 (floor), width PI_W+1 arithmetic, no wrap.
//  o_valid_tx: set the cycle ns enters START_REQ or END_REQ; cleared when i_busy_negedge_detected & ~i_valid_rx;
//   set takes priority if both occur the same cycle. Messages arriving with wrong code or without valid are ignored.
//  i_pt_done outside RUN ignored. Latency: min 2 cycles from START_RESP to first o_pt_en.
// CONFIGURATION
//  MBTRAIN_SB_TIMEOUT_EN defined: counter restarts on entering START_REQ/END_REQ; reaching TIMEOUT_CYC-1 -> DONE
//   with o_cal_fail=1, o_test_ack=1, o_sideband_message=0, o_pi_step unchanged.
//  Undefined: no counter; waits indefinitely; o_cal_fail only from empty window.
// STRUCTURE
//  mbtrain_pkg: message codes, FSM state enum, PI_W-derived widths.
//  Sub-module eye_window_tracker: clear, step_valid, step_pass, step_idx -> best_start, best_len, center.
// TESTING
//  All lanes pass at steps 5..9 only -> o_pi_step=7, o_cal_fail=0, END_REQ sent, o_test_ack=1 after msg 4.
//  Windows 2..3 and 10..11 (tie) -> center 2; windows 0..1 and 12..15 -> center 13 (run ending at last step).
//  One lane 0 at every step -> o_pi_step=0, o_cal_fail=1, end handshake still completes.
//  i_en dropped mid-RUN -> IDLE next cycle, o_pt_en=0, o_valid_tx=0; re-enable restarts sweep from step 0.
//  With MBTRAIN_SB_TIMEOUT_EN, no START_RESP for TIMEOUT_CYC cycles -> o_cal_fail=1, o_test_ack=1.
//  Busy negedge while i_valid_rx=1 -> o_valid_tx stays 1; same with i_valid_rx=0 -> clears next cycle.

Source files
------------

// File: rtl/mbtrain_center_sweep_tx_pkg.sv
// rtl/mbtrain_center_sweep_tx_pkg.sv - message codes, FSM state encodings and PI sweep helpers
package mbtrain_center_sweep_tx_pkg;

  typedef enum logic [3:0] {
    MSG_NONE       = 4'd0,
    MSG_START_REQ  = 4'd1,
    MSG_START_RESP = 4'd2,
    MSG_END_REQ    = 4'd3,
    MSG_END_RESP   = 4'd4
  } sb_msg_e;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START_REQ = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_EVAL      = 3'd4;
  localparam logic [2:0] ST_APPLY     = 3'd5;
  localparam logic [2:0] ST_END_REQ   = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  function automatic int pi_steps(input int pi_w);
    return 1 << pi_w;
  endfunction

endpackage

// File: rtl/mbtrain_center_sweep_tx_if.sv
// rtl/mbtrain_center_sweep_tx_if.sv - sideband and point-test signal bundle of the TX center sweep
interface mbtrain_center_sweep_tx_if #(
  parameter int NUM_LANES = 16,
  parameter int MSG_W     = 4,
  parameter int PI_W      = 4
);
  logic                 i_en;
  logic [MSG_W-1:0]     i_decoded_sideband_message;
  logic                 i_sideband_valid;
  logic                 i_busy_negedge_detected;
  logic                 i_valid_rx;
  logic                 i_mainband_or_valtrain_test;
  logic                 i_pt_done;
  logic [NUM_LANES-1:0] i_tx_lanes_result;
  logic [MSG_W-1:0]     o_sideband_message;
  logic                 o_valid_tx;
  logic                 o_pt_en;
  logic                 o_mainband_or_valtrain_test;
  logic [PI_W-1:0]      o_pi_step;
  logic                 o_test_ack;
  logic                 o_cal_fail;

  modport slave (
    input  i_en, i_decoded_sideband_message, i_sideband_valid, i_busy_negedge_detected,
           i_valid_rx, i_mainband_or_valtrain_test, i_pt_done, i_tx_lanes_result,
    output o_sideband_message, o_valid_tx, o_pt_en, o_mainband_or_valtrain_test,
           o_pi_step, o_test_ack, o_cal_fail
  );

  modport master (
    output i_en, i_decoded_sideband_message, i_sideband_valid, i_busy_negedge_detected,
           i_valid_rx, i_mainband_or_valtrain_test, i_pt_done, i_tx_lanes_result,
    input  o_sideband_message, o_valid_tx, o_pt_en, o_mainband_or_valtrain_test,
           o_pi_step, o_test_ack, o_cal_fail
  );
endinterface

// File: rtl/mbtrain_center_sweep_tx_eye_window_tracker.sv
// rtl/mbtrain_center_sweep_tx_eye_window_tracker.sv - longest contiguous passing PI window and its center
module mbtrain_center_sweep_tx_eye_window_tracker #(
  parameter int PI_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            step_valid_i,
  input  logic            step_pass_i,
  input  logic [PI_W-1:0] step_idx_i,
  output logic [PI_W:0]   best_len_o,
  output logic [PI_W:0]   center_o
);
  logic [PI_W:0] run_len_q, run_start_q, best_start_q, best_len_q;
  logic [PI_W:0] run_len_new, run_start_new;

  always_comb begin
    run_len_new   = run_len_q + 1'b1;
    run_start_new = (run_len_q == '0) ? {1'b0, step_idx_i} : run_start_q;
  end

  // Strict compare keeps the earliest window when two runs have equal length.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (step_valid_i) begin
      if (step_pass_i) begin
        run_len_q   <= run_len_new;
        run_start_q <= run_start_new;
        if (run_len_new > best_len_q) begin
          best_len_q   <= run_len_new;
          best_start_q <= run_start_new;
        end
      end else begin
        run_len_q <= '0;
      end
    end
  end

  always_comb begin
    center_o = best_start_q;
    if (best_len_q != '0) center_o = best_start_q + ((best_len_q - 1'b1) >> 1);
  end

  assign best_len_o = best_len_q;
endmodule

// File: rtl/mbtrain_center_sweep_tx.sv
// rtl/mbtrain_center_sweep_tx.sv - MBTRAIN TX center-calibration sweep sequencer; MBTRAIN_SB_TIMEOUT_EN adds response timeout
module mbtrain_center_sweep_tx
  import mbtrain_center_sweep_tx_pkg::*;
#(
  parameter int NUM_LANES   = 16,
  parameter int MSG_W       = 4,
  parameter int PI_W        = 4,
  parameter int TIMEOUT_CYC = 8000
) (
  input logic clk,
  input logic rst,
  mbtrain_center_sweep_tx_if.slave bus
);
  localparam int PI_STEPS = pi_steps(PI_W);

  logic [2:0]       state_q, state_d;
  logic [PI_W-1:0]  cur_q, pi_q;
  logic [MSG_W-1:0] msg_q;
  logic             valid_tx_q, pt_en_q, mb_q, ack_q, fail_q;
  logic             resp_start, resp_end, timeout, enter_req, last_step, step_valid;
  logic [PI_W:0]    best_len, center;

  assign resp_start = bus.i_sideband_valid && (bus.i_decoded_sideband_message == MSG_W'(MSG_START_RESP));
  assign resp_end   = bus.i_sideband_valid && (bus.i_decoded_sideband_message == MSG_W'(MSG_END_RESP));
  assign last_step  = (cur_q == PI_W'(PI_STEPS - 1));
  assign step_valid = (state_q == ST_RUN) && bus.i_pt_done;
  assign enter_req  = (state_d != state_q) && ((state_d == ST_START_REQ) || (state_d == ST_END_REQ));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_START_REQ;
      ST_START_REQ: if (resp_start) state_d = ST_SETTLE; else if (timeout) state_d = ST_DONE;
      ST_SETTLE:    state_d = ST_RUN;
      ST_RUN:       if (bus.i_pt_done) state_d = ST_EVAL;
      ST_EVAL:      state_d = last_step ? ST_APPLY : ST_SETTLE;
      ST_APPLY:     state_d = ST_END_REQ;
      ST_END_REQ:   if (resp_end || timeout) state_d = ST_DONE;
      default:      state_d = state_q;
    endcase
    if (!bus.i_en) state_d = ST_IDLE;
  end

`ifdef MBTRAIN_SB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             in_wait;

  assign in_wait = (state_q == ST_START_REQ) || (state_q == ST_END_REQ);
  assign timeout = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || enter_req) cnt_q <= '0;
    else if (in_wait)     cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !bus.i_en) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      msg_q      <= '0;
      valid_tx_q <= 1'b0;
      pt_en_q    <= 1'b0;
      mb_q       <= 1'b0;
      pi_q       <= '0;
      ack_q      <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_req) valid_tx_q <= 1'b1;
      else if (bus.i_busy_negedge_detected && !bus.i_valid_rx) valid_tx_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          msg_q <= MSG_W'(MSG_START_REQ);
          mb_q  <= bus.i_mainband_or_valtrain_test;
          cur_q <= '0;
        end
        ST_START_REQ, ST_END_REQ: begin
          if (state_d == ST_SETTLE) begin
            msg_q <= MSG_W'(MSG_NONE);
            pi_q  <= cur_q;
          end else if (state_d == ST_DONE) begin
            msg_q  <= MSG_W'(MSG_NONE);
            ack_q  <= 1'b1;
            fail_q <= fail_q | (timeout && !resp_end);
          end
        end
        ST_SETTLE: pt_en_q <= 1'b1;
        ST_RUN:    if (bus.i_pt_done) pt_en_q <= 1'b0;
        ST_EVAL: begin
          if (!last_step) begin
            cur_q <= cur_q + 1'b1;
            pi_q  <= cur_q + 1'b1;
          end else if (best_len == '0) begin
            pi_q   <= '0;
            fail_q <= 1'b1;
          end else begin
            pi_q <= PI_W'(center);
          end
        end
        ST_APPLY: msg_q <= MSG_W'(MSG_END_REQ);
        default: ;
      endcase
    end
  end

  // The tracker is cleared while idle so every enable starts a fresh sweep.
  mbtrain_center_sweep_tx_eye_window_tracker #(.PI_W(PI_W)) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == ST_IDLE),
    .step_valid_i (step_valid),
    .step_pass_i  (&bus.i_tx_lanes_result),
    .step_idx_i   (cur_q),
    .best_len_o   (best_len),
    .center_o     (center)
  );

  assign bus.o_sideband_message          = msg_q;
  assign bus.o_valid_tx                  = valid_tx_q;
  assign bus.o_pt_en                     = pt_en_q;
  assign bus.o_mainband_or_valtrain_test = mb_q;
  assign bus.o_pi_step                   = pi_q;
  assign bus.o_test_ack                  = ack_q;
  assign bus.o_cal_fail                  = fail_q;
endmodule

// File: tb/tb_mbtrain_center_sweep_tx.sv
// tb/tb_mbtrain_center_sweep_tx.sv - directed table-driven bench for the TX center sweep sequencer
module tb_mbtrain_center_sweep_tx;
  localparam int NL = 16;
  localparam int MW = 4;
  localparam int PW = 4;
  localparam int TO = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbtrain_center_sweep_tx_if #(.NUM_LANES(NL), .MSG_W(MW), .PI_W(PW)) bus();

  mbtrain_center_sweep_tx #(.NUM_LANES(NL), .MSG_W(MW), .PI_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] mask;
    logic        mb;
    logic [3:0]  exp_pi;
    logic        exp_fail;
  } vec_t;

  vec_t vecs[7];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_msg(input logic [3:0] m);
    bus.i_decoded_sideband_message = m;
    bus.i_sideband_valid = 1'b1;
    @(negedge clk);
    bus.i_decoded_sideband_message = '0;
    bus.i_sideband_valid = 1'b0;
  endtask

  // Point-test responder: answers each o_pt_en on its second cycle; loops until END_REQ appears.
  task automatic run_points(input logic [15:0] mask, input string tag);
    int exp_step = 0;
    int wc = 0;
    int k = 0;
    bit order_ok = 1'b1;
    while (!(bus.o_valid_tx && bus.o_sideband_message == 4'd3) && k < 3000) begin
      bus.i_pt_done = 1'b0;
      if (bus.o_pt_en) begin
        wc++;
        if (wc == 2) begin
          if (bus.o_pi_step != exp_step[3:0]) order_ok = 1'b0;
          bus.i_pt_done = 1'b1;
          bus.i_tx_lanes_result = mask[bus.o_pi_step] ? 16'hFFFF : ~(16'h1 << bus.o_pi_step);
          exp_step++;
          wc = 0;
        end
      end
      @(negedge clk);
      k++;
    end
    bus.i_pt_done = 1'b0;
    check({tag, " end_req"}, {bus.o_valid_tx, bus.o_sideband_message}, {1'b1, 4'd3});
    check({tag, " step_order"}, order_ok, 1);
    check({tag, " step_count"}, exp_step, 16);
  endtask

  task automatic do_sweep(input vec_t v, input string tag);
    bus.i_mainband_or_valtrain_test = v.mb;
    bus.i_en = 1'b1;
    @(negedge clk);
    check({tag, " start_req"}, {bus.o_valid_tx, bus.o_sideband_message}, {1'b1, 4'd1});
    send_msg(4'd2);
    run_points(v.mask, tag);
    check({tag, " pi_step"}, bus.o_pi_step, v.exp_pi);
    check({tag, " cal_fail"}, bus.o_cal_fail, v.exp_fail);
    check({tag, " mb_copy"}, bus.o_mainband_or_valtrain_test, v.mb);
    check({tag, " ack_early"}, bus.o_test_ack, 0);
    send_msg(4'd4);
    check({tag, " ack"}, {bus.o_test_ack, bus.o_sideband_message}, {1'b1, 4'd0});
    bus.i_en = 1'b0;
    @(negedge clk);
    check({tag, " cleared"}, {bus.o_test_ack, bus.o_valid_tx, bus.o_pi_step, bus.o_cal_fail}, 0);
  endtask

  initial begin
    vecs[0] = '{16'h03E0, 1'b0, 4'd7,  1'b0};
    vecs[1] = '{16'h0C0C, 1'b1, 4'd2,  1'b0};
    vecs[2] = '{16'hF003, 1'b0, 4'd13, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 4'd0,  1'b1};
    vecs[4] = '{16'hFFFF, 1'b1, 4'd7,  1'b0};
    vecs[5] = '{16'h8000, 1'b0, 4'd15, 1'b0};
    vecs[6] = '{16'h0077, 1'b0, 4'd1,  1'b0};

    bus.i_en = 1'b1;
    bus.i_decoded_sideband_message = '0;
    bus.i_sideband_valid = 1'b0;
    bus.i_busy_negedge_detected = 1'b0;
    bus.i_valid_rx = 1'b0;
    bus.i_mainband_or_valtrain_test = 1'b1;
    bus.i_pt_done = 1'b0;
    bus.i_tx_lanes_result = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.o_valid_tx, bus.o_sideband_message, bus.o_pt_en, bus.o_pi_step,
                            bus.o_test_ack, bus.o_cal_fail, bus.o_mainband_or_valtrain_test}, 0);
    bus.i_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_sweep(vecs[i], $sformatf("vec%0d", i));

    // Start latency, then enable dropped mid-RUN.
    bus.i_en = 1'b1;
    @(negedge clk);
    send_msg(4'd2);
    check("lat_settle_pt_en", bus.o_pt_en, 0);
    @(negedge clk);
    check("lat_run_pt_en", bus.o_pt_en, 1);
    bus.i_en = 1'b0;
    @(negedge clk);
    check("drop_en", {bus.o_pt_en, bus.o_valid_tx, bus.o_sideband_message, bus.o_pi_step}, 0);
    do_sweep(vecs[0], "reenable");

    // Busy release handling and ignored messages during START_REQ.
    bus.i_en = 1'b1;
    @(negedge clk);
    bus.i_busy_negedge_detected = 1'b1;
    bus.i_valid_rx = 1'b1;
    @(negedge clk);
    bus.i_busy_negedge_detected = 1'b0;
    bus.i_valid_rx = 1'b0;
    check("busy_rx_owns", bus.o_valid_tx, 1);
    bus.i_decoded_sideband_message = 4'd4;
    bus.i_sideband_valid = 1'b1;
    @(negedge clk);
    bus.i_decoded_sideband_message = 4'd2;
    bus.i_sideband_valid = 1'b0;
    bus.i_pt_done = 1'b1;
    @(negedge clk);
    bus.i_decoded_sideband_message = '0;
    bus.i_pt_done = 1'b0;
    repeat (2) @(negedge clk);
    check("ignored_msgs", {bus.o_pt_en, bus.o_sideband_message}, {1'b0, 4'd1});
    bus.i_busy_negedge_detected = 1'b1;
    @(negedge clk);
    bus.i_busy_negedge_detected = 1'b0;
    check("busy_release", bus.o_valid_tx, 0);
    send_msg(4'd2);
    run_points(16'h0030, "busy");
    check("busy pi_step", bus.o_pi_step, 4);
    send_msg(4'd4);
    check("busy ack", bus.o_test_ack, 1);
    bus.i_en = 1'b0;
    @(negedge clk);

`ifdef MBTRAIN_SB_TIMEOUT_EN
    begin
      int k = 0;
      bus.i_en = 1'b1;
      while (!bus.o_test_ack && k < TO + 20) begin
        @(negedge clk);
        k++;
      end
      check("timeout", {bus.o_test_ack, bus.o_cal_fail, bus.o_sideband_message}, {1'b1, 1'b1, 4'd0});
      bus.i_en = 1'b0;
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
